max_pool_2x2: RTL and testbench

- Streaming 2x2 stride-2 signed max-pool stage placed directly downstream of the conv stage in layer_1.
- Consumes conv results in raster order, qualified by the conv valid strobe.
- Emits one pooled pixel per 2x2 window, in raster order of the pooled map.
- Uses a half-width line buffer, so no full-frame storage is needed.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/pool_line_buf.sv | 27 ++
 rtl/max_pool_2x2.sv | 115 +++++++++++
 tb/tb_max_pool_2x2.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the layer-1 CNN datapath.
// Holds layer defaults and arithmetic helpers common to conv and pool stages.
package cnn_pkg;

    // Layer-1 defaults: 9-bit signed pixels on a 28x28 conv output map
    localparam int L1_PP    = 8;
    localparam int L1_IMG_W = 28;
    localparam int L1_IMG_H = 28;

    // Signed max. Callers sign-extend their operands into 32 bits and
    // truncate the result back, so the compare is exact for any pixel width.
    function automatic logic signed [31:0] smax(
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer for the 2x2 max-pool stage.
// Synchronous write, combinational read; no reset on the storage array.
module pool_line_buf #(
    parameter int DW    = 9,
    parameter int DEPTH = 14,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [DW-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic signed [DW-1:0] rdata
);

    logic signed [DW-1:0] mem [DEPTH];

    // Store the horizontal max of an even-row pair
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool, fed in raster order by the conv stage.
// Even rows park pair maxima in a half-width line buffer; odd rows emit results.
module max_pool_2x2
    import cnn_pkg::*;
#(
    parameter int PP    = L1_PP,
    parameter int IMG_W = L1_IMG_W,
    parameter int IMG_H = L1_IMG_H
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [PP:0]   pxl_in,
    input  logic                 valid_in,
    output logic signed [PP:0]   pool_out,
    output logic                 valid,
    output logic                 frame_last
);

    localparam int DW = PP + 1;
    localparam int HW = IMG_W / 2;
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int AW = (HW > 1) ? $clog2(HW) : 1;

    if ((IMG_W % 2) != 0 || IMG_W < 2 ||
        (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_dims
        $error("max_pool_2x2: IMG_W and IMG_H must be even and >= 2");
    end

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic signed [DW-1:0] h_q, h_d;
    logic signed [DW-1:0] pool_q, pool_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;

    logic signed [DW-1:0] hmax;
    logic signed [DW-1:0] lb_rdata;
    logic [AW-1:0]        lb_addr;
    logic                 lb_we;
    logic                 col_end;
    logic                 row_end;

    assign col_end = (col_q == CW'(IMG_W - 1));
    assign row_end = (row_q == RW'(IMG_H - 1));
    assign lb_addr = AW'(col_q >> 1);

    pool_line_buf #(
        .DW    (DW),
        .DEPTH (HW),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (hmax),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    // Next-state: raster counters, pair max, line-buffer write, pooled output
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        h_d     = h_q;
        pool_d  = pool_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        lb_we   = 1'b0;
        hmax    = DW'(smax(32'(h_q), 32'(pxl_in)));

        if (valid_in) begin
            if (!col_q[0]) begin
                h_d = pxl_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                pool_d  = DW'(smax(32'(lb_rdata), 32'(hmax)));
                valid_d = 1'b1;
                last_d  = col_end && row_end;
            end

            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset; line buffer is left as-is
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            h_q     <= '0;
            pool_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            h_q     <= h_d;
            pool_q  <= pool_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign pool_out   = pool_q;
    assign valid      = valid_q;
    assign frame_last = last_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2: a 4x4 instance for directed cases
// and a default 28x28 instance for a random frame, against a frame-array model.
module tb_max_pool_2x2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a, vin_a, v_a, fl_a;
    logic signed [8:0] px_a, po_a;
    logic              rst_b, vin_b, v_b, fl_b;
    logic signed [8:0] px_b, po_b;

    max_pool_2x2 #(.PP(8), .IMG_W(4), .IMG_H(4)) u_a (
        .clk        (clk),
        .reset      (rst_a),
        .pxl_in     (px_a),
        .valid_in   (vin_a),
        .pool_out   (po_a),
        .valid      (v_a),
        .frame_last (fl_a)
    );

    max_pool_2x2 u_b (
        .clk        (clk),
        .reset      (rst_b),
        .pxl_in     (px_b),
        .valid_in   (vin_b),
        .pool_out   (po_b),
        .valid      (v_b),
        .frame_last (fl_b)
    );

    int errs   = 0;
    int checks = 0;

    int sel, mw, mh, mr, mc, hold;
    int fr [28][28];
    int obs[$];
    int npulse, nlast;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic clr();
        obs.delete();
        npulse = 0;
        nlast  = 0;
    endtask

    // Drive one cycle on the selected instance and check its outputs after the edge
    task automatic step(input bit v, input int px);
        int ev, el, ov, opo, ofl;
        ev = 0;
        el = 0;
        if (sel == 0) begin
            vin_a = v; px_a = 9'(px); vin_b = 1'b0;
        end else begin
            vin_b = v; px_b = 9'(px); vin_a = 1'b0;
        end
        if (v) begin
            fr[mr][mc] = px;
            if ((mr % 2) == 1 && (mc % 2) == 1) begin
                ev   = 1;
                hold = mx(mx(fr[mr-1][mc-1], fr[mr-1][mc]),
                          mx(fr[mr][mc-1], px));
                el   = (mr == mh - 1 && mc == mw - 1) ? 1 : 0;
            end
            mc++;
            if (mc == mw) begin
                mc = 0;
                mr++;
                if (mr == mh) mr = 0;
            end
        end
        @(posedge clk);
        #1;
        ov  = (sel == 0) ? int'(v_a)  : int'(v_b);
        opo = (sel == 0) ? int'(po_a) : int'(po_b);
        ofl = (sel == 0) ? int'(fl_a) : int'(fl_b);
        chk("valid", ov, ev);
        chk("pool_out", opo, hold);
        chk("frame_last", ofl, el);
        if (ov != 0) begin
            obs.push_back(opo);
            npulse++;
            if (ofl != 0) nlast++;
        end
    endtask

    task automatic rst();
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        vin_a = 1'b0;
        vin_b = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", (sel == 0) ? int'(v_a) : int'(v_b), 0);
        chk("rst_pool", (sel == 0) ? int'(po_a) : int'(po_b), 0);
        chk("rst_last", (sel == 0) ? int'(fl_a) : int'(fl_b), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        mr = 0;
        mc = 0;
        hold = 0;
    endtask

    task automatic chk_seq(input string tag, input int exp[$]);
        chk({tag, "_count"}, obs.size(), exp.size());
        foreach (exp[i]) begin
            chk(tag, (i < obs.size()) ? obs[i] : -9999, exp[i]);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        vin_a = 1'b0; vin_b = 1'b0;
        px_a  = '0;   px_b  = '0;
        sel = 0; mw = 4; mh = 4; mr = 0; mc = 0; hold = 0;
        clr();
        @(posedge clk);
        #1;
        chk("init_valid_b", int'(v_b), 0);
        chk("init_pool_b", int'(po_b), 0);
        rst_b = 1'b0;

        // Ramp frame, valid_in held high
        rst();
        clr();
        for (int i = 0; i < 16; i++) step(1'b1, i);
        step(1'b0, 0);
        chk_seq("ramp", '{5, 7, 13, 15});
        chk("ramp_nlast", nlast, 1);

        // Most-negative values with one slightly larger pixel
        clr();
        for (int i = 0; i < 16; i++) step(1'b1, (i == 5) ? -255 : -256);
        step(1'b0, 0);
        chk_seq("neg", '{-255, -256, -256, -256});

        // Ramp frame with alternating then random bubbles
        clr();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i);
            if (i < 8) step(1'b0, 99);
            else repeat ($urandom_range(0, 3)) step(1'b0, $urandom_range(0, 255));
        end
        step(1'b0, 0);
        chk_seq("bubble", '{5, 7, 13, 15});
        chk("bubble_nlast", nlast, 1);

        // Back-to-back frames without an idle cycle
        clr();
        for (int i = 0; i < 16; i++) step(1'b1, i);
        for (int i = 0; i < 16; i++) step(1'b1, 15 - i);
        step(1'b0, 0);
        chk_seq("b2b", '{5, 7, 13, 15, 15, 13, 7, 5});
        chk("b2b_nlast", nlast, 2);

        // Reset in the middle of a frame, then a clean frame
        for (int i = 0; i < 6; i++) step(1'b1, 100 + i);
        rst();
        clr();
        for (int i = 0; i < 16; i++) step(1'b1, i);
        step(1'b0, 0);
        chk_seq("midrst", '{5, 7, 13, 15});

        // Default 28x28 instance with a random signed frame
        sel = 1; mw = 28; mh = 28;
        rst();
        clr();
        for (int i = 0; i < 28 * 28; i++) begin
            step(1'b1, int'($urandom_range(0, 511)) - 256);
            if ($urandom_range(0, 7) == 0) step(1'b0, 0);
        end
        step(1'b0, 0);
        chk("big_pulses", npulse, 196);
        chk("big_nlast", nlast, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
